// File: rtl/divide.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define DIV_FAST_PATH_EN to finish zero-divisor, signed-overflow and divide-by-one in one cycle.
module divide #(
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 kill,
    input  logic [1:0]           op_type,
    input  logic [DATA_SIZE-1:0] data_1,
    input  logic [DATA_SIZE-1:0] data_2,
    output logic                 busy,
    output logic                 ready,
    output logic [DATA_SIZE-1:0] result
);
    // state | meaning
    // IDLE  | waiting for enable
    // CALC  | one quotient bit per cycle, DATA_SIZE cycles
    // FIX   | sign correction, quotient/remainder select into result
    // DONE  | result valid, ready pulse
    localparam int CNT_W = $clog2(DATA_SIZE);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [DATA_SIZE:0]   r_rem;
    logic [DATA_SIZE-1:0] r_quo;
    logic [DATA_SIZE-1:0] r_dvs;
    logic [DATA_SIZE-1:0] r_result;
    logic                 r_q_sign;
    logic                 r_r_sign;
    logic                 r_is_rem;

    logic                 w_signed;
    logic                 w_neg_1;
    logic                 w_neg_2;
    logic                 w_dvs_zero;
    logic [DATA_SIZE-1:0] w_abs_1;
    logic [DATA_SIZE-1:0] w_abs_2;
    logic [DATA_SIZE+1:0] w_shift;
    logic [DATA_SIZE+1:0] w_trial;
    logic [DATA_SIZE-1:0] w_quo_fix;
    logic [DATA_SIZE-1:0] w_rem_fix;

    assign w_signed   = ~op_type[0];
    assign w_neg_1    = w_signed & data_1[DATA_SIZE-1];
    assign w_neg_2    = w_signed & data_2[DATA_SIZE-1];
    assign w_abs_1    = w_neg_1 ? -data_1 : data_1;
    assign w_abs_2    = w_neg_2 ? -data_2 : data_2;
    assign w_dvs_zero = (data_2 == '0);

    // One guard bit above R so the trial subtraction's sign is its MSB.
    assign w_shift   = {r_rem, r_quo[DATA_SIZE-1]};
    assign w_trial   = w_shift - {2'b00, r_dvs};
    assign w_quo_fix = r_q_sign ? -r_quo : r_quo;
    assign w_rem_fix = r_r_sign ? -r_rem[DATA_SIZE-1:0] : r_rem[DATA_SIZE-1:0];

`ifdef DIV_FAST_PATH_EN
    logic                 w_ovf;
    logic                 w_fast;
    logic [DATA_SIZE-1:0] w_fast_res;

    assign w_ovf  = w_signed && (data_1 == {1'b1, {(DATA_SIZE-1){1'b0}}}) && (data_2 == '1);
    assign w_fast = w_dvs_zero | w_ovf | (data_2 == DATA_SIZE'(1));
    // Overflow and divide-by-one share the same answer: quotient = dividend, remainder = 0.
    assign w_fast_res = w_dvs_zero ? (op_type[1] ? data_1 : '1)
                                   : (op_type[1] ? '0 : data_1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_result <= '0;
            r_q_sign <= 1'b0;
            r_r_sign <= 1'b0;
            r_is_rem <= 1'b0;
        end else if (kill) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_rem    <= '0;
                        r_quo    <= w_abs_1;
                        r_dvs    <= w_abs_2;
                        r_q_sign <= (w_neg_1 ^ w_neg_2) & ~w_dvs_zero;
                        r_r_sign <= w_neg_1;
                        r_is_rem <= op_type[1];
                        r_cnt    <= CNT_W'(DATA_SIZE - 1);
`ifdef DIV_FAST_PATH_EN
                        if (w_fast) begin
                            r_result <= w_fast_res;
                            r_state  <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
`else
                        r_state <= CALC;
`endif
                    end
                end
                CALC: begin
                    r_quo <= {r_quo[DATA_SIZE-2:0], ~w_trial[DATA_SIZE+1]};
                    r_rem <= w_trial[DATA_SIZE+1] ? w_shift[DATA_SIZE:0] : w_trial[DATA_SIZE:0];
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                FIX: begin
                    r_result <= r_is_rem ? w_rem_fix : w_quo_fix;
                    r_state  <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy   = (r_state != IDLE);
    assign ready  = (r_state == DONE);
    assign result = r_result;

endmodule
